// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand pair loader: collection FSM states,
// default sizing, and the bit positions of A and B inside a packed pair.
package operand_loader_pkg;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    localparam int NIB_W_DEF = 4;
    localparam int DEPTH_DEF = 2;
    localparam int CNT_W_DEF = 8;

    // A sits in the upper half of the pair, B in the lower half.
    localparam int PAIR_A_MSB_DEF = 2*NIB_W_DEF - 1;
    localparam int PAIR_A_LSB_DEF = NIB_W_DEF;
    localparam int PAIR_B_MSB_DEF = NIB_W_DEF - 1;
    localparam int PAIR_B_LSB_DEF = 0;

    function automatic int pair_a_lsb(input int nib_w);
        return nib_w;
    endfunction

    function automatic int pair_a_msb(input int nib_w);
        return 2*nib_w - 1;
    endfunction

    function automatic int pair_b_msb(input int nib_w);
        return nib_w - 1;
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// First-word-fall-through FIFO: head entry visible combinationally, 1-cycle push-to-visible.
// Push while full and pop while empty are dropped; caller gates push with o_full.
module pair_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_head_dat,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == LVL_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers are log2(DEPTH) wide, so natural overflow wraps them modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    assign o_head_dat = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/operand_pair_loader.sv
// Pairs serial A/B nibbles into {A,B} and queues them; pair visible 1 cycle after the B transfer.
// in_ready drops only while waiting for B with the FIFO full; no combinational path from out_ready.
module operand_pair_loader
    import operand_loader_pkg::*;
#(
    parameter  int NIB_W = NIB_W_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIB_W-1:0]     in_nibble,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*NIB_W-1:0]   out_pair,
    output logic [CNT_W-1:0]     pair_count,
    output logic [LVL_W-1:0]     level
);

    localparam int A_MSB = pair_a_msb(NIB_W);
    localparam int A_LSB = pair_a_lsb(NIB_W);
    localparam int B_MSB = pair_b_msb(NIB_W);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NIB_W-1:0]     r_a;
    logic [NIB_W-1:0]     w_a_nxt;
    logic [CNT_W-1:0]     r_pair_count;
    logic                 w_push;
    logic [2*NIB_W-1:0]   w_push_dat;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_out_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_A;
            r_a     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
        end
    end

    // Abort wins over a B transfer in the same cycle; in WAIT_A it is simply ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_push      = 1'b0;
        in_ready    = 1'b1;
        case (r_state)
            WAIT_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_a_nxt     = in_nibble;
                    w_state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                in_ready = !w_full;
                if (abort) begin
                    w_a_nxt     = '0;
                    w_state_nxt = WAIT_A;
                end else if (in_valid && !w_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = WAIT_A;
                end
            end
            default: begin
                w_state_nxt = WAIT_A;
            end
        endcase
    end

    always_comb begin
        w_push_dat              = '0;
        w_push_dat[A_MSB:A_LSB] = r_a;
        w_push_dat[B_MSB:0]     = in_nibble;
    end

    pair_fifo #(
        .W     (2*NIB_W),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (out_ready),
        .o_head_dat (out_pair),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (level)
    );

    assign out_valid  = !w_empty;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pair_count <= '0;
        end else if (w_out_xfer) begin
            r_pair_count <= r_pair_count + 1'b1;
        end
    end

    assign pair_count = r_pair_count;

endmodule

// File: tb/tb_operand_pair_loader.sv
// Scoreboard bench for operand_pair_loader: pairs queued as driven, compared as popped.
module tb_operand_pair_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_nibble;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pair;
    logic [7:0] pair_count;
    logic [1:0] level;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_pops   = 0;
    logic [7:0] exp_cnt  = '0;
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    operand_pair_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_nibble  (in_nibble),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pair   (out_pair),
        .pair_count (pair_count),
        .level      (level)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output side of the scoreboard: every output transfer must match the oldest queued pair.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pop", {24'h0, out_pair}, 32'hFFFF_FFFF);
            end else begin
                check("out_pair", {24'h0, out_pair}, {24'h0, sb_q.pop_front()});
            end
            exp_cnt = exp_cnt + 8'd1;
            n_pops++;
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_nibble = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        exp_cnt = '0;
    endtask

    // Presents one nibble until it is accepted; returns at 1 time unit after the transfer edge.
    task automatic xfer(input logic [3:0] n);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_nibble = n;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
        xfer(a);
        xfer(b);
        sb_q.push_back({a, b});
    endtask

    task automatic pop_cycles(input int n);
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_in_ready",   {31'h0, in_ready},   32'd1);
        check("rst_out_valid",  {31'h0, out_valid},  32'd0);
        check("rst_out_pair",   {24'h0, out_pair},   32'd0);
        check("rst_pair_count", {24'h0, pair_count}, 32'd0);
        check("rst_level",      {30'h0, level},      32'd0);

        // First pair 0x3,0x5 with 1-cycle latency
        @(posedge clk); #1;
        xfer(4'h3);
        @(negedge clk);
        check("lat_before_b", {31'h0, out_valid}, 32'd0);
        @(posedge clk); #1;
        xfer(4'h5);
        sb_q.push_back(8'h35);
        @(negedge clk);
        check("lat_valid", {31'h0, out_valid}, 32'd1);
        check("lat_pair",  {24'h0, out_pair},  32'h35);
        check("lat_level", {30'h0, level},     32'd1);
        @(posedge clk); #1;
        pop_cycles(1);
        @(negedge clk);
        check("pop1_count", {24'h0, pair_count}, {24'h0, exp_cnt});
        check("pop1_count_abs", {24'h0, pair_count}, 32'd1);
        check("pop1_valid", {31'h0, out_valid},  32'd0);

        // Backpressure: fill the FIFO, then hold off B
        @(posedge clk); #1;
        send_pair(4'h1, 4'h2);
        send_pair(4'h3, 4'h4);
        @(negedge clk);
        check("bp_level_full", {30'h0, level},    32'd2);
        check("bp_ready_a",    {31'h0, in_ready}, 32'd1);
        @(posedge clk); #1;
        xfer(4'h6);
        in_valid  = 1'b1;
        in_nibble = 4'h7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_held", {31'h0, in_ready}, 32'd0);
            check("bp_level_held", {30'h0, level},    32'd2);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after_pop", {31'h0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(8'h67);
        @(negedge clk);
        check("bp_level_refill", {30'h0, level}, 32'd2);
        check("bp_head", {24'h0, out_pair}, 32'h34);
        @(posedge clk); #1;
        pop_cycles(2);
        @(negedge clk);
        check("bp_drained", {30'h0, level}, 32'd0);
        check("bp_count", {24'h0, pair_count}, 32'd4);

        // Abort in WAIT_B drops the held A and the concurrent nibble
        @(posedge clk); #1;
        xfer(4'hA);
        abort     = 1'b1;
        in_valid  = 1'b1;
        in_nibble = 4'hB;
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_level", {30'h0, level},     32'd0);
        check("abort_valid", {31'h0, out_valid}, 32'd0);
        @(posedge clk); #1;
        send_pair(4'hC, 4'hD);
        @(negedge clk);
        check("abort_pair", {24'h0, out_pair}, 32'hCD);
        @(posedge clk); #1;
        pop_cycles(1);

        // Abort in WAIT_A has no effect
        abort = 1'b1;
        xfer(4'hE);
        abort = 1'b0;
        xfer(4'hF);
        sb_q.push_back(8'hEF);
        @(negedge clk);
        check("abort_a_pair", {24'h0, out_pair}, 32'hEF);
        @(posedge clk); #1;
        pop_cycles(1);

        // Simultaneous push and pop at level 1
        send_pair(4'h1, 4'h2);
        xfer(4'h3);
        in_valid  = 1'b1;
        in_nibble = 4'h4;
        out_ready = 1'b1;
        @(negedge clk);
        check("pp_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb_q.push_back(8'h34);
        @(negedge clk);
        check("pp_level", {30'h0, level},    32'd1);
        check("pp_head",  {24'h0, out_pair}, 32'h34);
        @(posedge clk); #1;
        pop_cycles(1);
        @(negedge clk);
        check("pre_wrap_count", {24'h0, pair_count}, {24'h0, exp_cnt});

        // 256 pairs with continuous input and output: counter wraps to 0
        do_reset();
        n_pops    = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i * 37 + 11);
            send_pair(v[7:4], v[3:0]);
        end
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("wrap_pops",  n_pops, 32'd256);
        check("wrap_count", {24'h0, pair_count}, 32'd0);
        check("wrap_level", {30'h0, level},      32'd0);
        check("wrap_sb",    sb_q.size(),         32'd0);

        // Reset in the middle of a pair with a full FIFO
        @(posedge clk); #1;
        send_pair(4'h5, 4'h5);
        pop_cycles(1);
        send_pair(4'h1, 4'h2);
        send_pair(4'h3, 4'h4);
        xfer(4'h9);
        @(negedge clk);
        check("mid_level", {30'h0, level}, 32'd2);
        check("mid_count", {24'h0, pair_count}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        check("mrst_level", {30'h0, level},      32'd0);
        check("mrst_valid", {31'h0, out_valid},  32'd0);
        check("mrst_pair",  {24'h0, out_pair},   32'd0);
        check("mrst_count", {24'h0, pair_count}, 32'd0);
        check("mrst_ready", {31'h0, in_ready},   32'd1);
        @(posedge clk); #1;
        send_pair(4'h1, 4'h1);
        @(negedge clk);
        check("mrst_next_pair", {24'h0, out_pair}, 32'h11);
        @(posedge clk); #1;
        pop_cycles(1);
        @(negedge clk);
        check("final_count", {24'h0, pair_count}, 32'd1);
        check("final_sb",    sb_q.size(),         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
